// File: rtl/key_debounce_arbiter.sv
// key_debounce_arbiter: debounces ten push-button inputs and drives exactly
// one tone-divider enable, lowest key index winning.
// Optional feature: define KEY_SUSTAIN_EN to hold the last note for
// SUSTAIN_CNT cycles after every key has been released.
module key_debounce_arbiter #(
  parameter int DEBOUNCE_CNT = 20000,
  parameter int SUSTAIN_CNT  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  output logic [9:0] key_out,
  output logic       key_valid,
  output logic [3:0] key_idx
);

  localparam int NKEYS = 10;
  localparam int CW    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
`ifdef KEY_SUSTAIN_EN
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam int SW = (SUSTAIN_CNT > 1) ? $clog2(SUSTAIN_CNT) : 1;
  localparam logic [SW-1:0] SUS_MAX = SW'(SUSTAIN_CNT - 1);
  logic [SW-1:0] r_sus_cnt;
`else
  // The hold time only matters when the sustain feature is built in.
  logic w_unused_sustain;
  assign w_unused_sustain = ^SUSTAIN_CNT;
`endif

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] r_deb;
  logic [CW-1:0]    r_cnt [NKEYS];
  logic [1:0]       r_state;
  logic [9:0]       r_key_out;
  logic             r_key_valid;
  logic [3:0]       r_key_idx;

  logic             w_any;
  logic [3:0]       w_win_idx;
  logic [9:0]       w_win_onehot;

  // Two-flop synchronizer: the raw buttons are asynchronous to clk.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its inputs from before the edge, regardless of statement order.
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: a level change is accepted only after DEBOUNCE_CNT
  // consecutive samples disagree with the current debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      // NOTE: this counter array is a handful of flops whose value must be
      // known after reset (an abort of any debounce in flight), so it is
      // cleared element by element rather than treated as an unreset memory.
      for (int k = 0; k < NKEYS; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DB_MAX) begin
          r_deb[k] <= ~r_deb[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Priority pick: lowest-index debounced key wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (r_deb[k]) begin
        w_any     = 1'b1;
        w_win_idx = 4'(k);
      end
    end
    w_win_onehot = w_any ? (10'b1 << w_win_idx) : '0;
  end

  // Arbiter FSM with registered note outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_key_idx   <= '0;
`ifdef KEY_SUSTAIN_EN
      r_sus_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_PLAY;
            r_key_out   <= w_win_onehot;
            r_key_valid <= 1'b1;
            r_key_idx   <= w_win_idx;
          end
        end
        ST_PLAY: begin
          if (w_any) begin
            // Winner changes switch notes directly, never through silence.
            r_key_out   <= w_win_onehot;
            r_key_valid <= 1'b1;
            r_key_idx   <= w_win_idx;
          end else begin
`ifdef KEY_SUSTAIN_EN
            r_state     <= ST_SUSTAIN;
            r_sus_cnt   <= '0;
`else
            r_state     <= ST_IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_key_idx   <= '0;
`endif
          end
        end
`ifdef KEY_SUSTAIN_EN
        ST_SUSTAIN: begin
          if (w_any) begin
            r_state     <= ST_PLAY;
            r_key_out   <= w_win_onehot;
            r_key_valid <= 1'b1;
            r_key_idx   <= w_win_idx;
            r_sus_cnt   <= '0;
          end else if (r_sus_cnt == SUS_MAX) begin
            r_state     <= ST_IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_key_idx   <= '0;
            r_sus_cnt   <= '0;
          end else begin
            r_sus_cnt   <= r_sus_cnt + SW'(1);
          end
        end
`endif
        default: begin
          r_state     <= ST_IDLE;
          r_key_out   <= '0;
          r_key_valid <= 1'b0;
          r_key_idx   <= '0;
        end
      endcase
    end
  end

  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign key_idx   = r_key_idx;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Bench for key_debounce_arbiter (DEBOUNCE_CNT=4, SUSTAIN_CNT=8). Follows
// KEY_SUSTAIN_EN the same way the design does.
module tb_key_debounce_arbiter;

  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_in;
  logic [9:0] key_out;
  logic       key_valid;
  logic [3:0] key_idx;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  key_debounce_arbiter #(.DEBOUNCE_CNT(D), .SUSTAIN_CNT(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_idx   (key_idx)
  );

  // Reference model: the debouncer sees key_in delayed two edges; a key's
  // level flips once its last D seen samples all disagree with it. The note
  // is the lowest pressed debounced key, one edge later.
  logic [9:0] m_d1, m_d2, m_deb, m_out;
  logic [3:0] m_idx;
  logic [9:0] m_smp[$];
  bit         m_sus;
  int         m_rem;

  function automatic int lowest(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    bit flip;
    logic [9:0] s;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_deb = '0; m_out = '0; m_idx = '0;
      m_smp.delete(); m_sus = 0; m_rem = 0;
      return;
    end
    w = lowest(m_deb);
    if (w >= 0) begin
      m_out = 10'(1) << w; m_idx = 4'(w); m_sus = 0;
    end
`ifdef KEY_SUSTAIN_EN
    else if (m_sus) begin
      m_rem--;
      if (m_rem == 0) begin m_out = '0; m_idx = '0; m_sus = 0; end
    end else if (m_out != '0) begin
      m_sus = 1; m_rem = S;
    end
`else
    else begin
      m_out = '0; m_idx = '0;
    end
`endif
    m_smp.push_back(m_d2);
    if (m_smp.size() > D) void'(m_smp.pop_front());
    if (m_smp.size() == D) begin
      for (int k = 0; k < 10; k++) begin
        flip = 1;
        for (int j = 0; j < D; j++) begin
          s = m_smp[j];
          if (s[k] == m_deb[k]) flip = 0;
        end
        if (flip) m_deb[k] = ~m_deb[k];
      end
    end
    m_d2 = m_d1;
    m_d1 = key_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 10'h3FF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({key_out, key_valid, key_idx} !== 15'd0) begin
        n_bad++;
        $display("FAIL reset: got out=%h valid=%b idx=%0d, want all zero", key_out, key_valid, key_idx);
      end
    end
    rst = 1'b0; key_in = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_total++;
      if ({key_out, key_valid, key_idx} !== {m_out, |m_out, m_idx}) begin
        n_bad++;
        $display("FAIL post_reset: got out=%h valid=%b idx=%0d, want out=%h idx=%0d", key_out, key_valid, key_idx, m_out, m_idx);
      end
    end
  endtask

  // Single key raised at cycle 0: visible from cycle 7, not earlier.
  task automatic test_latency();
    logic [9:0] exp;
    do_reset();
    key_in = 10'h008;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c >= 7) ? 10'h008 : 10'h000;
      n_total++;
      if (key_out !== exp || key_valid !== (c >= 7) || key_idx !== ((c >= 7) ? 4'd3 : 4'd0)
          || key_out !== m_out) begin
        n_bad++;
        $display("FAIL latency c=%0d: got out=%h valid=%b idx=%0d, want out=%h", c, key_out, key_valid, key_idx, exp);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    key_in = 10'h020;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 3) key_in = '0;
      n_total++;
      if (key_out !== 10'h000 || key_valid !== 1'b0 || key_out !== m_out) begin
        n_bad++;
        $display("FAIL glitch c=%0d: got out=%h valid=%b, want out=000", c, key_out, key_valid);
      end
    end
  endtask

  // Key 7 held, key 2 pressed then released: direct note switching.
  task automatic test_priority_switch();
    logic [9:0] exp;
    do_reset();
    key_in = 10'h080;
    for (int c = 0; c < 9; c++) tick();
    n_total++;
    if (key_out !== 10'h080) begin
      n_bad++;
      $display("FAIL prio_hold: got out=%h, want out=080", key_out);
    end
    key_in = 10'h084;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c >= 7) ? 10'h004 : 10'h080;
      n_total++;
      if (key_out !== exp || key_out !== m_out) begin
        n_bad++;
        $display("FAIL prio_press c=%0d: got out=%h, want out=%h", c, key_out, exp);
      end
    end
    key_in = 10'h080;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c >= 7) ? 10'h080 : 10'h004;
      n_total++;
      if (key_out !== exp || key_idx !== ((c >= 7) ? 4'd7 : 4'd2)) begin
        n_bad++;
        $display("FAIL prio_release c=%0d: got out=%h idx=%0d, want out=%h", c, key_out, key_idx, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    key_in = 10'h210;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_total++;
      if (key_out !== ((c >= 7) ? 10'h010 : 10'h000) || key_idx !== ((c >= 7) ? 4'd4 : 4'd0)) begin
        n_bad++;
        $display("FAIL simultaneous c=%0d: got out=%h idx=%0d, want out=%h", c, key_out, key_idx,
                 (c >= 7) ? 10'h010 : 10'h000);
      end
    end
  endtask

  task automatic test_release();
    logic [9:0] exp;
    int off_at;
`ifdef KEY_SUSTAIN_EN
    off_at = 7 + S;
`else
    off_at = 7;
`endif
    do_reset();
    key_in = 10'h008;
    for (int c = 0; c < 9; c++) tick();
    key_in = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = (c < off_at) ? 10'h008 : 10'h000;
      n_total++;
      if (key_out !== exp || key_valid !== (c < off_at) || key_out !== m_out) begin
        n_bad++;
        $display("FAIL release c=%0d: got out=%h valid=%b, want out=%h", c, key_out, key_valid, exp);
      end
    end
  endtask

  // Reset during play, during a debounce and (if built) during sustain.
  task automatic test_reset_mid();
    logic [9:0] exp;
    do_reset();
    key_in = 10'h002;
    for (int c = 0; c < 9; c++) tick();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        key_in = 10'h040;
        for (int c = 0; c < 4; c++) tick();
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_total++;
      if ({key_out, key_valid, key_idx} !== 15'd0) begin
        n_bad++;
        $display("FAIL reset_mid pass=%0d: got out=%h valid=%b idx=%0d, want all zero", pass, key_out, key_valid, key_idx);
      end
      for (int c = 1; c <= 9; c++) begin
        tick();
        exp = (c >= 7) ? key_in : 10'h000;
        n_total++;
        if (key_out !== exp || key_out !== m_out) begin
          n_bad++;
          $display("FAIL reset_resume pass=%0d c=%0d: got out=%h, want out=%h", pass, c, key_out, exp);
        end
      end
    end
`ifdef KEY_SUSTAIN_EN
    key_in = '0;
    for (int c = 0; c < 9; c++) tick();
    n_total++;
    if (key_out !== 10'h040) begin
      n_bad++;
      $display("FAIL sustain_hold: got out=%h, want out=040", key_out);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_total++;
      if (key_out !== 10'h000) begin
        n_bad++;
        $display("FAIL sustain_abort c=%0d: got out=%h, want out=000", c, key_out);
      end
    end
`endif
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(3) == 0) key_in = '0;
        else key_in = 10'($urandom & $urandom & 32'h3FF);
        hold = $urandom_range(20, 1);
      end
      hold--;
      rst = ($urandom_range(249) == 0);
      tick();
      n_total++;
      if ({key_out, key_valid, key_idx} !== {m_out, |m_out, m_idx} || !$onehot0(key_out)) begin
        n_bad++;
        $display("FAIL random c=%0d: got out=%h valid=%b idx=%0d, want out=%h valid=%b idx=%0d",
                 c, key_out, key_valid, key_idx, m_out, |m_out, m_idx);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_in = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_priority_switch();
    test_simultaneous();
    test_release();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
